// File: rtl/volatility_engine_pkg.sv
// Shared FSM state encoding and width helpers for the rolling-window volatility engine.
package volatility_engine_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StUpdate,
    StCalc,
    StOut,
    StClear
  } state_e;

  function automatic int unsigned sum_width(input int unsigned dw, input int unsigned l2w);
    return dw + l2w;
  endfunction

  function automatic int unsigned sumsq_width(input int unsigned dw, input int unsigned l2w);
    return 2 * dw + l2w;
  endfunction

  function automatic int unsigned mean_width(input int unsigned dw, input int unsigned frac);
    return dw + frac;
  endfunction

  function automatic int unsigned var_width(input int unsigned dw, input int unsigned frac);
    return 2 * dw + frac;
  endfunction

endpackage

// File: rtl/vol_ring_buffer.sv
// Per-channel sample window: ring storage, write pointer and saturating fill counter.
module vol_ring_buffer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LOG2_WINDOW = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_clear,
  output logic [DATA_WIDTH-1:0] o_oldest,
  output logic                  o_full
);

  localparam int unsigned Window = 2 ** LOG2_WINDOW;

  logic [DATA_WIDTH-1:0]  mem_q [Window];
  logic [LOG2_WINDOW-1:0] ptr_q;
  logic [LOG2_WINDOW:0]   fill_q;

  // Fill saturates at exactly Window, so its MSB alone marks a full window.
  assign o_full   = fill_q[LOG2_WINDOW];
  assign o_oldest = o_full ? mem_q[ptr_q] : '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ptr_q  <= '0;
      fill_q <= '0;
      for (int i = 0; i < Window; i++) mem_q[i] <= '0;
    end else if (i_clear) begin
      ptr_q  <= '0;
      fill_q <= '0;
      for (int i = 0; i < Window; i++) mem_q[i] <= '0;
    end else if (i_wr_en) begin
      mem_q[ptr_q] <= i_wr_data;
      ptr_q        <= ptr_q + 1'b1;
      if (!o_full) fill_q <= fill_q + 1'b1;
    end
  end

endmodule

// File: rtl/volatility_engine.sv
// Multi-channel rolling mean/variance engine: mid-price in, windowed statistics out.
module volatility_engine
  import volatility_engine_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LOG2_WINDOW = 5,
  parameter int unsigned NUM_STOCKS  = 4,
  parameter int unsigned FRAC_BITS   = 16
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [$clog2(NUM_STOCKS)-1:0]     i_stock_id,
  input  logic [DATA_WIDTH-1:0]             i_best_bid,
  input  logic [DATA_WIDTH-1:0]             i_best_ask,
  input  logic                              i_clear,
  output logic                              o_valid,
  output logic [$clog2(NUM_STOCKS)-1:0]     o_stock_id,
  output logic [DATA_WIDTH-1:0]             o_price,
  output logic [DATA_WIDTH+FRAC_BITS-1:0]   o_mean,
  output logic [2*DATA_WIDTH+FRAC_BITS-1:0] o_variance,
  output logic                              o_warm,
  output logic                              o_reject
);

  localparam int unsigned IdW   = $clog2(NUM_STOCKS);
  localparam int unsigned SumW  = sum_width(DATA_WIDTH, LOG2_WINDOW);
  localparam int unsigned SqW   = sumsq_width(DATA_WIDTH, LOG2_WINDOW);
  localparam int unsigned MeanW = mean_width(DATA_WIDTH, FRAC_BITS);
  localparam int unsigned VarW  = var_width(DATA_WIDTH, FRAC_BITS);
  localparam int unsigned ProdW = 2 * SumW;

  state_e                state_q, state_d;
  logic                  accept, reject, both_empty;
  logic [DATA_WIDTH-1:0] pick_price;
  logic [IdW-1:0]        id_q;
  logic [DATA_WIDTH-1:0] price_q, old_q;
  logic [SumW-1:0]       sum_q   [NUM_STOCKS];
  logic [SqW-1:0]        sumsq_q [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] rb_oldest [NUM_STOCKS];
  logic                  rb_full   [NUM_STOCKS];
  logic [SqW-1:0]        old_sq, new_sq;
  logic [SumW-1:0]       cur_sum;
  logic [SqW-1:0]        cur_sq;
  logic [ProdW-1:0]      spread;

  always_comb begin
    both_empty = (i_best_bid == '0) && (i_best_ask == '0);
    if (i_best_ask == '0) begin
      pick_price = i_best_bid;
    end else if (i_best_bid == '0) begin
      pick_price = i_best_ask;
    end else begin
      pick_price = DATA_WIDTH'(({1'b0, i_best_bid} + {1'b0, i_best_ask}) >> 1);
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_clear) begin
          state_d = StClear;
        end else if (i_valid) begin
          if (both_empty) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = StRead;
          end
        end
      end
      StRead:   state_d = StUpdate;
      StUpdate: state_d = StCalc;
      StCalc:   state_d = StOut;
      StOut:    state_d = StIdle;
      StClear:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign o_ready = (state_q == StIdle);
  assign o_valid = (state_q == StOut);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= StIdle;
      id_q     <= '0;
      price_q  <= '0;
      old_q    <= '0;
      o_reject <= 1'b0;
    end else begin
      state_q  <= state_d;
      o_reject <= reject;
      if (accept || (state_q == StIdle && i_clear)) id_q <= i_stock_id;
      if (accept) price_q <= pick_price;
      if (state_q == StRead) old_q <= rb_oldest[id_q];
    end
  end

  assign old_sq  = SqW'(old_q) * SqW'(old_q);
  assign new_sq  = SqW'(price_q) * SqW'(price_q);
  assign cur_sum = sum_q[id_q];
  assign cur_sq  = sumsq_q[id_q];
  // W*sumsq >= sum^2 always, so the unsigned difference never underflows.
  assign spread  = {cur_sq, {LOG2_WINDOW{1'b0}}} - ProdW'(cur_sum) * ProdW'(cur_sum);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_STOCKS; k++) begin
        sum_q[k]   <= '0;
        sumsq_q[k] <= '0;
      end
    end else if (state_q == StUpdate) begin
      sum_q[id_q]   <= cur_sum - SumW'(old_q) + SumW'(price_q);
      sumsq_q[id_q] <= cur_sq - old_sq + new_sq;
    end else if (state_q == StClear) begin
      sum_q[id_q]   <= '0;
      sumsq_q[id_q] <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_stock_id <= '0;
      o_price    <= '0;
      o_mean     <= '0;
      o_variance <= '0;
      o_warm     <= 1'b0;
    end else if (state_q == StCalc) begin
      o_stock_id <= id_q;
      o_price    <= price_q;
      o_mean     <= MeanW'({cur_sum, {FRAC_BITS{1'b0}}} >> LOG2_WINDOW);
      o_variance <= VarW'({spread, {FRAC_BITS{1'b0}}} >> (2 * LOG2_WINDOW));
      o_warm     <= rb_full[id_q];
    end
  end

  for (genvar k = 0; k < NUM_STOCKS; k++) begin : g_chan
    localparam logic [IdW-1:0] Idx = IdW'(k);
    vol_ring_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .LOG2_WINDOW(LOG2_WINDOW)
    ) u_ring (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_wr_en  (state_q == StUpdate && id_q == Idx),
      .i_wr_data(price_q),
      .i_clear  (state_q == StClear && id_q == Idx),
      .o_oldest (rb_oldest[k]),
      .o_full   (rb_full[k])
    );
  end

endmodule

// File: doc/volatility_engine.md
VOLATILITY_ENGINE -- requirements
Module: volatility_engine

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  DATA_WIDTH, 32, unsigned price width.
  LOG2_WINDOW, 5, log2 of the samples per rolling window (WINDOW = 2**LOG2_WINDOW).
  NUM_STOCKS, 4, number of independent channels.
  FRAC_BITS, 16, fractional bits on the mean and variance outputs.
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset come first.
  i_clk, in, 1, the single clock.
  i_reset, in, 1, asynchronous active-high reset.
  i_valid, in, 1, sample offer.
  o_ready, out, 1, engine can accept a sample.
  i_stock_id, in, $clog2(NUM_STOCKS), channel of the sample.
  i_best_bid, in, DATA_WIDTH, best bid (0 = empty side).
  i_best_ask, in, DATA_WIDTH, best ask (0 = empty side).
  i_clear, in, 1, request to flush the channel given by i_stock_id.
  o_valid, out, 1, one-cycle result strobe.
  o_stock_id, out, $clog2(NUM_STOCKS), channel of the result.
  o_price, out, DATA_WIDTH, sample price that was stored.
  o_mean, out, DATA_WIDTH+FRAC_BITS, window mean, unsigned Q(DATA_WIDTH).FRAC_BITS.
  o_variance, out, 2*DATA_WIDTH+FRAC_BITS, window variance, unsigned Q(2*DATA_WIDTH).FRAC_BITS.
  o_warm, out, 1, channel has received at least WINDOW samples.
  o_reject, out, 1, one-cycle strobe: sample had both sides 0.

Function
REQ-003 The engine SHALL contain one FSM with states IDLE, READ, UPDATE, CALC, OUT. o_ready SHALL be 1 only in IDLE.
REQ-004 A sample SHALL be accepted on a cycle where i_valid=1 and o_ready=1. The accepted stock id and price SHALL be registered.
REQ-005 Price selection:
  both sides nonzero: (bid+ask)>>1, computed at DATA_WIDTH+1 bits with no overflow.
  ask==0: bid.
  bid==0: ask.
REQ-006 A sample with bid==0 and ask==0 SHALL NOT be stored. It SHALL pulse o_reject for 1 cycle and the FSM SHALL stay in IDLE.
REQ-007 Each channel SHALL own a WINDOW-deep ring buffer, a LOG2_WINDOW-bit write pointer and a fill counter that saturates at WINDOW.
REQ-008 READ: fetch the oldest entry at the channel's write pointer. The entry is 0 while the buffer is not yet full.
REQ-009 UPDATE, sum registers:
  sum (DATA_WIDTH+LOG2_WINDOW bits) SHALL become sum - old + new.
  sumsq (2*DATA_WIDTH+LOG2_WINDOW bits) SHALL become sumsq - old^2 + new^2.
  All arithmetic SHALL be exact with no wrap.
REQ-010 UPDATE, buffer: the new price SHALL be written to the buffer. The pointer SHALL increment modulo WINDOW and the fill counter SHALL increment.
REQ-011 CALC:
  o_mean = (sum << FRAC_BITS) >> LOG2_WINDOW.
  o_variance = (((sumsq << LOG2_WINDOW) - sum^2) << FRAC_BITS) >> (2*LOG2_WINDOW).
  The subtraction SHALL be unsigned and is never negative.
REQ-012 OUT: o_valid SHALL be 1 for exactly one cycle with all result fields stable, then the FSM SHALL return to IDLE. Latency from accept to o_valid is 4 cycles and throughput is 1 sample per 5 cycles.
REQ-013 Before the window is full, o_warm SHALL be 0 and the statistics SHALL treat empty slots as 0. o_warm SHALL be 1 on the WINDOW-th and all later results of that channel.
REQ-014 i_clear in IDLE SHALL zero that channel's sums, pointer, fill counter and buffer entries within WINDOW cycles, holding o_ready=0 meanwhile. The other channels SHALL be untouched.
REQ-015 If i_clear and i_valid are both 1 in IDLE, clear SHALL win and the sample SHALL be dropped.
REQ-016 i_clear outside IDLE SHALL be ignored.
REQ-017 Result outputs SHALL hold their last values between strobes.

Reset
REQ-018 i_reset SHALL take effect asynchronously and force:
  FSM to IDLE.
  o_valid=0, o_reject=0, o_warm=0.
  o_price, o_mean, o_variance, o_stock_id all 0.
  Every sum, pointer, fill counter and buffer entry to 0.
  o_ready=1 on the first clock after release.
REQ-019 Reset mid-operation SHALL abandon the in-flight sample with no partial update surviving.

Structure
REQ-020 A shared package SHALL hold the FSM state enum and the width helper constants (sum, sumsq, mean and variance widths).
REQ-021 The per-channel ring buffer with its pointer and fill counter SHALL be one sub-module, vol_ring_buffer, instantiated NUM_STOCKS times, or once with the channel index folded into the address.

Verification
REQ-022 Reset, then bid=100, ask=102 on stock 0 -> o_valid 4 cycles after accept with o_price=101, o_mean=101*2^16/32, o_warm=0.
REQ-023 32 identical samples of price 500 on stock 1 -> the 32nd result has o_warm=1, o_mean=500<<16, o_variance=0.
REQ-024 Alternate 100/102 for 64 samples on stock 2 -> after warm, o_mean=101<<16 and o_variance=1<<16 on every result.
REQ-025 bid=0, ask=0 -> o_reject pulses once, no o_valid, stock sums unchanged. bid=0, ask=300 -> o_price=300.
REQ-026 Fill stock 3, then i_clear with i_valid together on stock 3 -> sample dropped, next result on stock 3 has o_warm=0. Stocks 0-2 results are unchanged.
REQ-027 Assert i_reset during CALC -> o_valid stays 0. After release, the first sample behaves as after a fresh reset.
